// File: rtl/n64_vinput_demux_pkg.sv
// Shared definitions for the N64 video input demux: sync-word bit positions,
// pixel and line-counter widths, PAL threshold and the pixel-phase encoding.
package n64_vinput_demux_pkg;

    localparam int SYNC_VSYNC_BIT = 3;
    localparam int SYNC_CLAMP_BIT = 2;
    localparam int SYNC_HSYNC_BIT = 1;
    localparam int SYNC_CSYNC_BIT = 0;

    localparam int COLOR_W    = 7;
    localparam int PIXEL_W    = 3 * COLOR_W;
    localparam int LINE_CNT_W = 10;

    localparam logic [LINE_CNT_W-1:0] DEFAULT_PAL_THRESH = 10'd290;
    localparam int                    DEFAULT_HOLD_FIELDS = 2;

    // Which word of the pixel is expected next; PH_WAIT means a sync word is due.
    typedef enum logic [1:0] {
        PH_R    = 2'd0,
        PH_G    = 2'd1,
        PH_B    = 2'd2,
        PH_WAIT = 2'd3
    } phase_t;

    function automatic logic [LINE_CNT_W-1:0] sat_inc(input logic [LINE_CNT_W-1:0] value);
        return (&value) ? value : value + 1'b1;
    endfunction

endpackage

// File: rtl/n64_vinput_fieldclass.sv
// Field classifier: counts hsync falls per field, reports the line count at each
// vsync fall and filters the PAL / interlace decisions over consecutive fields.
module n64_vinput_fieldclass
    import n64_vinput_demux_pkg::*;
#(
    parameter logic [LINE_CNT_W-1:0] pal_line_thresh = DEFAULT_PAL_THRESH,
    parameter int                    hold_fields     = DEFAULT_HOLD_FIELDS
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  sync_stb,
    input  logic                  hsync,
    input  logic                  vsync,
    output logic [LINE_CNT_W-1:0] field_lines_o,
    output logic                  pal_o,
    output logic                  interlaced_o
);

    localparam int                HOLD_W    = $clog2(hold_fields + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(hold_fields - 1);

    logic                  prev_hsync;
    logic                  prev_vsync;
    logic [LINE_CNT_W-1:0] line_cnt;
    logic [LINE_CNT_W-1:0] prev_field_cnt;
    logic                  first_done;
    logic [HOLD_W-1:0]     pal_cnt;
    logic [HOLD_W-1:0]     il_cnt;
    logic                  h_fall;
    logic                  v_fall;
    logic                  cand_pal;
    logic                  cand_il;

    assign h_fall   = sync_stb & prev_hsync & ~hsync;
    assign v_fall   = sync_stb & prev_vsync & ~vsync;
    assign cand_pal = (line_cnt >= pal_line_thresh);
    assign cand_il  = (line_cnt != prev_field_cnt);

    // A simultaneous hsync fall belongs to the new field, so it restarts the count at 1.
    always_ff @(posedge clock) begin
        if (reset) begin
            prev_hsync     <= 1'b1;
            prev_vsync     <= 1'b1;
            line_cnt       <= '0;
            prev_field_cnt <= '0;
            first_done     <= 1'b0;
            pal_cnt        <= '0;
            il_cnt         <= '0;
            field_lines_o  <= '0;
            pal_o          <= 1'b0;
            interlaced_o   <= 1'b0;
        end else if (sync_stb) begin
            prev_hsync <= hsync;
            prev_vsync <= vsync;
            if (v_fall) begin
                field_lines_o  <= line_cnt;
                prev_field_cnt <= line_cnt;
                first_done     <= 1'b1;
                line_cnt       <= h_fall ? LINE_CNT_W'(1) : '0;
                if (first_done) begin
                    if (cand_pal == pal_o) begin
                        pal_cnt <= '0;
                    end else if (pal_cnt == HOLD_LAST) begin
                        pal_o   <= ~pal_o;
                        pal_cnt <= '0;
                    end else begin
                        pal_cnt <= pal_cnt + 1'b1;
                    end
                    if (cand_il == interlaced_o) begin
                        il_cnt <= '0;
                    end else if (il_cnt == HOLD_LAST) begin
                        interlaced_o <= ~interlaced_o;
                        il_cnt       <= '0;
                    end else begin
                        il_cnt <= il_cnt + 1'b1;
                    end
                end
            end else if (h_fall) begin
                line_cnt <= sat_inc(line_cnt);
            end
        end
    end

endmodule

// File: rtl/n64_vinput_demux.sv
// N64 video input demux: turns the sync/R/G/B word stream into 21-bit pixels.
// Optional macro N64_VDEMUX_ERRCNT_EN adds a saturating framing-error counter.
module n64_vinput_demux
    import n64_vinput_demux_pkg::*;
#(
    parameter int                    color_width_i   = COLOR_W,
    parameter logic [LINE_CNT_W-1:0] pal_line_thresh = DEFAULT_PAL_THRESH,
    parameter int                    hold_fields     = DEFAULT_HOLD_FIELDS
) (
    input  logic                         N64_CLK_i,
    input  logic                         N64_RST_i,
    input  logic                         nVDSYNC_i,
    input  logic [color_width_i-1:0]     VD_i,
    output logic                         vdata_valid_o,
    output logic [3*color_width_i-1:0]   vdata_o,
    output logic                         vsync_o,
    output logic                         clamp_o,
    output logic                         hsync_o,
    output logic                         csync_o,
    output logic [LINE_CNT_W-1:0]        field_lines_o,
    output logic                         pal_o,
    output logic                         interlaced_o,
    output logic                         sync_err_o
`ifdef N64_VDEMUX_ERRCNT_EN
    ,
    output logic [7:0]                   err_cnt_o
`endif
);

    phase_t                   phase;
    logic [3:0]               sync_word;
    logic [color_width_i-1:0] r_cap;
    logic [color_width_i-1:0] g_cap;
    logic                     err_evt;

    // Framing error: a sync word interrupting a pixel, or a data word with no pixel open.
    assign err_evt = nVDSYNC_i ? (phase == PH_WAIT) : (phase != PH_WAIT);

    always_ff @(posedge N64_CLK_i) begin
        if (N64_RST_i) begin
            phase         <= PH_WAIT;
            sync_word     <= '0;
            r_cap         <= '0;
            g_cap         <= '0;
            vdata_valid_o <= 1'b0;
            vdata_o       <= '0;
            vsync_o       <= 1'b0;
            clamp_o       <= 1'b0;
            hsync_o       <= 1'b0;
            csync_o       <= 1'b0;
            sync_err_o    <= 1'b0;
        end else begin
            vdata_valid_o <= 1'b0;
            if (err_evt) begin
                sync_err_o <= 1'b1;
            end
            if (!nVDSYNC_i) begin
                sync_word <= VD_i[3:0];
                phase     <= PH_R;
            end else begin
                case (phase)
                    PH_R: begin
                        r_cap <= VD_i;
                        phase <= PH_G;
                    end
                    PH_G: begin
                        g_cap <= VD_i;
                        phase <= PH_B;
                    end
                    PH_B: begin
                        vdata_valid_o <= 1'b1;
                        vdata_o       <= {r_cap, g_cap, VD_i};
                        vsync_o       <= sync_word[SYNC_VSYNC_BIT];
                        clamp_o       <= sync_word[SYNC_CLAMP_BIT];
                        hsync_o       <= sync_word[SYNC_HSYNC_BIT];
                        csync_o       <= sync_word[SYNC_CSYNC_BIT];
                        phase         <= PH_WAIT;
                    end
                    default: phase <= PH_WAIT;
                endcase
            end
        end
    end

`ifdef N64_VDEMUX_ERRCNT_EN
    always_ff @(posedge N64_CLK_i) begin
        if (N64_RST_i) begin
            err_cnt_o <= '0;
        end else if (err_evt && err_cnt_o != 8'hFF) begin
            err_cnt_o <= err_cnt_o + 8'd1;
        end
    end
`endif

    n64_vinput_fieldclass #(
        .pal_line_thresh (pal_line_thresh),
        .hold_fields     (hold_fields)
    ) u_fieldclass (
        .clock         (N64_CLK_i),
        .reset         (N64_RST_i),
        .sync_stb      (~nVDSYNC_i),
        .hsync         (VD_i[SYNC_HSYNC_BIT]),
        .vsync         (VD_i[SYNC_VSYNC_BIT]),
        .field_lines_o (field_lines_o),
        .pal_o         (pal_o),
        .interlaced_o  (interlaced_o)
    );

endmodule

// File: tb/tb_n64_vinput_demux.sv
// Self-checking bench for n64_vinput_demux: directed word streams, a word-level
// reference model compared every cycle, and literal spot checks.
module tb_n64_vinput_demux;

    logic        N64_CLK_i = 1'b0;
    logic        N64_RST_i = 1'b1;
    logic        nVDSYNC_i = 1'b1;
    logic [6:0]  VD_i      = '0;
    logic        vdata_valid_o;
    logic [20:0] vdata_o;
    logic        vsync_o, clamp_o, hsync_o, csync_o;
    logic [9:0]  field_lines_o;
    logic        pal_o, interlaced_o, sync_err_o;
`ifdef N64_VDEMUX_ERRCNT_EN
    logic [7:0]  err_cnt_o;
`endif

    int checks_total  = 0;
    int checks_passed = 0;

    n64_vinput_demux dut (
        .N64_CLK_i     (N64_CLK_i),
        .N64_RST_i     (N64_RST_i),
        .nVDSYNC_i     (nVDSYNC_i),
        .VD_i          (VD_i),
        .vdata_valid_o (vdata_valid_o),
        .vdata_o       (vdata_o),
        .vsync_o       (vsync_o),
        .clamp_o       (clamp_o),
        .hsync_o       (hsync_o),
        .csync_o       (csync_o),
        .field_lines_o (field_lines_o),
        .pal_o         (pal_o),
        .interlaced_o  (interlaced_o),
        .sync_err_o    (sync_err_o)
`ifdef N64_VDEMUX_ERRCNT_EN
        ,
        .err_cnt_o     (err_cnt_o)
`endif
    );

    always #5 N64_CLK_i = ~N64_CLK_i;

    // Reference model state, expressed in terms of words and fields.
    localparam int HOLD = 2;
    bit          model_ready = 1'b0;
    bit          m_have_sync;
    int          m_pend_n;
    logic [6:0]  m_pend [3];
    logic [3:0]  m_sync;
    bit          m_prev_h, m_prev_v;
    int          m_lines, m_fields, m_prev_count;
    bit          pal_hist[$];
    bit          il_hist[$];
    bit          exp_valid, exp_err, exp_pal, exp_il;
    logic [20:0] exp_vdata;
    logic [3:0]  exp_sync;
    int          exp_errcnt, exp_lines;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks_total++;
        if (actual === expected) checks_passed++;
        else $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    endtask

    function automatic bit filtered(input bit hist[$], input bit current);
        if (hist.size() < HOLD) return current;
        for (int i = 1; i <= HOLD; i++)
            if (hist[hist.size() - i] == current) return current;
        return !current;
    endfunction

    task automatic modelError();
        exp_err = 1'b1;
        if (exp_errcnt < 255) exp_errcnt++;
    endtask

    task automatic modelCloseField(input int count);
        exp_lines = count;
        m_fields++;
        if (m_fields > 1) begin
            pal_hist.push_back(count >= 290);
            il_hist.push_back(count != m_prev_count);
            exp_pal = filtered(pal_hist, exp_pal);
            exp_il  = filtered(il_hist, exp_il);
        end
        m_prev_count = count;
    endtask

    initial forever begin
        @(posedge N64_CLK_i);
        exp_valid = 1'b0;
        if (N64_RST_i) begin
            model_ready = 1'b1;
            m_have_sync = 1'b0; m_pend_n = 0; m_sync = '0;
            m_prev_h = 1'b1; m_prev_v = 1'b1;
            m_lines = 0; m_fields = 0; m_prev_count = 0;
            pal_hist.delete(); il_hist.delete();
            exp_err = 1'b0; exp_pal = 1'b0; exp_il = 1'b0;
            exp_vdata = '0; exp_sync = '0; exp_errcnt = 0; exp_lines = 0;
        end else if (!nVDSYNC_i) begin
            bit hf, vf;
            if (m_have_sync && m_pend_n < 3) modelError();
            m_have_sync = 1'b1;
            m_pend_n    = 0;
            m_sync      = VD_i[3:0];
            hf = m_prev_h && !VD_i[1];
            vf = m_prev_v && !VD_i[3];
            if (vf) begin
                modelCloseField(m_lines);
                m_lines = hf ? 1 : 0;
            end else if (hf && m_lines < 1023) begin
                m_lines++;
            end
            m_prev_h = VD_i[1];
            m_prev_v = VD_i[3];
        end else if (m_have_sync && m_pend_n < 3) begin
            m_pend[m_pend_n] = VD_i;
            m_pend_n++;
            if (m_pend_n == 3) begin
                exp_valid = 1'b1;
                exp_vdata = {m_pend[0], m_pend[1], m_pend[2]};
                exp_sync  = m_sync;
            end
        end else begin
            modelError();
        end
    end

    initial forever begin
        @(negedge N64_CLK_i);
        if (model_ready) begin
            checkOutput("pixel", {vdata_valid_o, vdata_o, vsync_o, clamp_o, hsync_o, csync_o},
                        {exp_valid, exp_vdata, exp_sync});
`ifdef N64_VDEMUX_ERRCNT_EN
            checkOutput("status", {err_cnt_o, sync_err_o}, {8'(exp_errcnt), exp_err});
`else
            checkOutput("status", {31'd0, sync_err_o}, {31'd0, exp_err});
`endif
            checkOutput("field", {field_lines_o, pal_o, interlaced_o}, {10'(exp_lines), exp_pal, exp_il});
        end
    end

    task automatic applyStimulus(input logic nsync, input logic [6:0] vd);
        nVDSYNC_i = nsync;
        VD_i      = vd;
        @(posedge N64_CLK_i);
        #2;
    endtask

    task automatic doReset();
        N64_RST_i = 1'b1;
        nVDSYNC_i = 1'b1;
        VD_i      = '0;
        repeat (2) @(posedge N64_CLK_i);
        #2;
        N64_RST_i = 1'b0;
    endtask

    task automatic sendPixel(input logic [3:0] s, input logic [6:0] r, input logic [6:0] g, input logic [6:0] b);
        applyStimulus(1'b0, {3'b000, s});
        applyStimulus(1'b1, r);
        applyStimulus(1'b1, g);
        applyStimulus(1'b1, b);
    endtask

    function automatic logic [3:0] syncWord(input logic h, input logic v);
        return {v, 1'b1, h, h & v};
    endfunction

    task automatic sendField(input int lines, input bit combined);
        for (int i = 0; i < lines; i++) begin
            sendPixel(syncWord(1'b0, 1'b1), 7'(i), 7'(i * 3), 7'(i * 5));
            sendPixel(syncWord(1'b1, 1'b1), 7'(i + 9), 7'(i * 7), 7'(i ^ 7'h55));
        end
        if (combined) sendPixel(syncWord(1'b0, 1'b0), 7'h01, 7'h02, 7'h03);
        else          sendPixel(syncWord(1'b1, 1'b0), 7'h01, 7'h02, 7'h03);
        sendPixel(syncWord(1'b1, 1'b1), 7'h04, 7'h05, 7'h06);
    endtask

    initial begin
        doReset();
        checkOutput("reset_outputs", {vdata_valid_o, vdata_o, sync_err_o, field_lines_o, pal_o, interlaced_o}, 32'd0);

        sendPixel(4'hF, 7'h11, 7'h22, 7'h33);
        checkOutput("first_valid", vdata_valid_o, 1);
        checkOutput("first_data", vdata_o, 21'h045133);
        checkOutput("first_sync", {vsync_o, clamp_o, hsync_o, csync_o}, 4'hF);
        checkOutput("first_no_err", sync_err_o, 0);
        sendPixel(4'hF, 7'h11, 7'h22, 7'h33);

        // Partial pixel: sync word after only R and G.
        applyStimulus(1'b0, 7'h0F);
        applyStimulus(1'b1, 7'h11);
        applyStimulus(1'b1, 7'h22);
        sendPixel(4'hF, 7'h44, 7'h55, 7'h66);
        checkOutput("partial_err", sync_err_o, 1);
        checkOutput("after_partial_data", vdata_o, 21'h112AE6);
`ifdef N64_VDEMUX_ERRCNT_EN
        checkOutput("partial_errcnt", err_cnt_o, 1);
`endif

        // Five data words without a sync word.
        doReset();
        sendPixel(4'hF, 7'h01, 7'h02, 7'h03);
        repeat (5) applyStimulus(1'b1, 7'h7F);
        checkOutput("overrun_err", sync_err_o, 1);
        checkOutput("overrun_no_strobe", vdata_valid_o, 0);
        sendPixel(4'hF, 7'h0A, 7'h0B, 7'h0C);
        checkOutput("overrun_recover", vdata_valid_o, 1);
`ifdef N64_VDEMUX_ERRCNT_EN
        checkOutput("overrun_errcnt", err_cnt_o, 5);
`endif

        // Field classification.
        doReset();
        sendField(312, 1'b0);
        sendField(312, 1'b0);
        checkOutput("pal_held", pal_o, 0);
        sendField(312, 1'b0);
        checkOutput("lines_312", field_lines_o, 312);
        checkOutput("pal_rise", pal_o, 1);
        checkOutput("progressive", interlaced_o, 0);
        sendField(262, 1'b0);
        checkOutput("pal_hold", pal_o, 1);
        sendField(262, 1'b0);
        checkOutput("pal_fall", pal_o, 0);
        checkOutput("lines_262", field_lines_o, 262);
        sendField(263, 1'b0);
        sendField(262, 1'b0);
        checkOutput("il_rise", interlaced_o, 1);
        sendField(263, 1'b0);
        sendField(263, 1'b0);
        checkOutput("il_hold", interlaced_o, 1);
        sendField(263, 1'b0);
        checkOutput("il_fall", interlaced_o, 0);

        // hsync and vsync falling in the same sync word.
        sendField(100, 1'b1);
        checkOutput("combined_close", field_lines_o, 100);
        sendField(50, 1'b0);
        checkOutput("combined_next", field_lines_o, 51);

        // Reset in the middle of a pixel.
        applyStimulus(1'b0, 7'h0F);
        applyStimulus(1'b1, 7'h11);
        N64_RST_i = 1'b1;
        applyStimulus(1'b1, 7'h22);
        N64_RST_i = 1'b0;
        checkOutput("midreset_outputs", {vdata_valid_o, vdata_o, sync_err_o, field_lines_o, pal_o, interlaced_o}, 32'd0);
        applyStimulus(1'b0, 7'h0F);
        checkOutput("midreset_no_strobe", vdata_valid_o, 0);
        applyStimulus(1'b1, 7'h21);
        applyStimulus(1'b1, 7'h42);
        applyStimulus(1'b1, 7'h63);
        checkOutput("midreset_recover", {vdata_valid_o, sync_err_o}, 2'b10);
        repeat (3) @(posedge N64_CLK_i);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
